// File: rtl/vend_mux_ctrl_if.sv
// Coin/pay panel bundle: raw active-low buttons toward the controller,
// multiplexed display and status pulses back toward the board.
interface vend_mux_ctrl_if #(
  parameter int DIGITS = 2
);
  logic              co5;
  logic              co10;
  logic              co50;
  logic              pay;
  logic              cancel;
  logic [6:0]        seg;
  logic [DIGITS-1:0] ctrl;
  logic              payok;
  logic              change;
  logic              reject;
  logic              err;

  // Board side: drives the buttons, observes display and status.
  modport master (
    output co5, co10, co50, pay, cancel,
    input  seg, ctrl, payok, change, reject, err
  );

  // Controller side.
  modport slave (
    input  co5, co10, co50, pay, cancel,
    output seg, ctrl, payok, change, reject, err
  );
endinterface

// File: rtl/vend_mux_ctrl.sv
// Vending controller: synchronises and debounces the panel buttons, keeps a
// saturating credit, vends at PRICE, pays change as a pulse train and scans an
// N-digit active-low 7-segment display showing the credit in decimal.
module vend_mux_ctrl #(
  parameter int PRICE       = 15,
  parameter int MAX_CREDIT  = 95,
  parameter int DIGITS      = 2,
  parameter int DB_CYCLES   = 500000,
  parameter int SCAN_DIV    = 500000,
  parameter int VEND_CYCLES = 1000,
  parameter int PULSE_GAP   = 1000
) (
  input  logic           ck,
  input  logic           reset,
  vend_mux_ctrl_if.slave pnl
);

  localparam int CW  = $clog2(MAX_CREDIT + 1);
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int SCW = $clog2(SCAN_DIV + 1);
  localparam int VCW = $clog2(VEND_CYCLES + 1);
  localparam int GCW = $clog2(PULSE_GAP + 1);

  typedef enum logic [1:0] {COLLECT = 2'd0, VEND = 2'd1, CHANGE = 2'd2} state_t;

  // Binary to packed BCD (four digits) by shift-and-add-3.
  function automatic logic [15:0] bin2bcd(input logic [13:0] bin);
    logic [29:0] sh;
    sh = {16'd0, bin};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sh[14+4*d +: 4] >= 4'd5) sh[14+4*d +: 4] = sh[14+4*d +: 4] + 4'd3;
        else                         sh[14+4*d +: 4] = sh[14+4*d +: 4];
      end
      sh = sh << 1;
    end
    return sh[29:14];
  endfunction

  // Active-low gfedcba pattern for one decimal digit.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Button bit order: 0 co5, 1 co10, 2 co50, 3 pay, 4 cancel.
  logic [4:0]     raw_s;
  logic [4:0]     s1_r, s2_r, lvl_r, ev_r;
  logic [DBW-1:0] db_cnt_r [5];

  state_t         state_r, state_nxt;
  logic [CW-1:0]  credit_r, credit_nxt;
  logic [VCW-1:0] vcnt_r, vcnt_nxt;
  logic [GCW-1:0] gcnt_r, gcnt_nxt;
  logic           payok_r, payok_nxt, change_r, change_nxt;
  logic           reject_r, reject_nxt, err_r, err_nxt;
  logic           coin_any_s;
  logic [15:0]    coin_val_s, sum_s;

  logic [SCW-1:0]    scan_cnt_r;
  logic [1:0]        digit_r;
  logic [15:0]       bcd_s, high_s;
  logic [3:0]        dig_val_s;
  logic              blank_s;
  logic [6:0]        seg_r;
  logic [DIGITS-1:0] ctrl_r;

  assign raw_s = {pnl.cancel, pnl.pay, pnl.co50, pnl.co10, pnl.co5};

  // Two-flop synchroniser plus counting debouncer; event on debounced fall.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      s1_r  <= 5'b11111;
      s2_r  <= 5'b11111;
      lvl_r <= 5'b11111;
      ev_r  <= 5'b00000;
      for (int i = 0; i < 5; i++) db_cnt_r[i] <= {DBW{1'b0}};
    end else begin
      s1_r <= raw_s;
      s2_r <= s1_r;
      for (int i = 0; i < 5; i++) begin
        if (s2_r[i] != lvl_r[i]) begin
          if (db_cnt_r[i] == DBW'(DB_CYCLES - 1)) begin
            lvl_r[i]    <= s2_r[i];
            db_cnt_r[i] <= {DBW{1'b0}};
            ev_r[i]     <= ~s2_r[i];
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + 1'b1;
            ev_r[i]     <= 1'b0;
          end
        end else begin
          db_cnt_r[i] <= {DBW{1'b0}};
          ev_r[i]     <= 1'b0;
        end
      end
    end
  end

  // Highest-value coin wins when several arrive together.
  always_comb begin
    coin_any_s = |ev_r[2:0];
    coin_val_s = 16'd0;
    if (ev_r[2])      coin_val_s = 16'd50;
    else if (ev_r[1]) coin_val_s = 16'd10;
    else if (ev_r[0]) coin_val_s = 16'd5;
    else              coin_val_s = 16'd0;
    sum_s = 16'(credit_r) + coin_val_s;
  end

  // Next-state and next-output logic of the vend FSM.
  always_comb begin
    state_nxt  = state_r;
    credit_nxt = credit_r;
    vcnt_nxt   = vcnt_r;
    gcnt_nxt   = gcnt_r;
    payok_nxt  = 1'b0;
    change_nxt = 1'b0;
    reject_nxt = 1'b0;
    err_nxt    = 1'b0;
    case (state_r)
      COLLECT: begin
        if (ev_r[4]) begin
          if (credit_r != {CW{1'b0}}) begin
            state_nxt  = CHANGE;
            change_nxt = 1'b1;
            gcnt_nxt   = {GCW{1'b0}};
          end else begin
            state_nxt  = COLLECT;
          end
        end else if (ev_r[3]) begin
          if (credit_r >= CW'(PRICE)) begin
            credit_nxt = credit_r - CW'(PRICE);
            state_nxt  = VEND;
            payok_nxt  = 1'b1;
            vcnt_nxt   = {VCW{1'b0}};
          end else begin
            err_nxt    = 1'b1;
          end
        end else if (coin_any_s) begin
          if (sum_s <= 16'(MAX_CREDIT)) credit_nxt = CW'(sum_s);
          else                          reject_nxt = 1'b1;
        end else begin
          state_nxt = COLLECT;
        end
      end
      VEND: begin
        reject_nxt = coin_any_s;
        if (vcnt_r == VCW'(VEND_CYCLES - 1)) begin
          if (credit_r != {CW{1'b0}}) begin
            state_nxt  = CHANGE;
            change_nxt = 1'b1;
            gcnt_nxt   = {GCW{1'b0}};
          end else begin
            state_nxt  = COLLECT;
          end
        end else begin
          payok_nxt = 1'b1;
          vcnt_nxt  = vcnt_r + 1'b1;
        end
      end
      CHANGE: begin
        reject_nxt = coin_any_s;
        // The pulse cycle retires 5 units; the last one ends the train.
        if (change_r && (credit_r <= CW'(5))) begin
          credit_nxt = {CW{1'b0}};
          state_nxt  = COLLECT;
          gcnt_nxt   = {GCW{1'b0}};
        end else begin
          if (change_r) credit_nxt = credit_r - CW'(5);
          else          credit_nxt = credit_r;
          if (gcnt_r == GCW'(PULSE_GAP - 1)) begin
            gcnt_nxt   = {GCW{1'b0}};
            change_nxt = 1'b1;
          end else begin
            gcnt_nxt   = gcnt_r + 1'b1;
          end
        end
      end
      default: begin
        state_nxt  = COLLECT;
        credit_nxt = {CW{1'b0}};
      end
    endcase
  end

  // FSM state, credit and registered status pulses.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state_r  <= COLLECT;
      credit_r <= {CW{1'b0}};
      vcnt_r   <= {VCW{1'b0}};
      gcnt_r   <= {GCW{1'b0}};
      payok_r  <= 1'b0;
      change_r <= 1'b0;
      reject_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      credit_r <= credit_nxt;
      vcnt_r   <= vcnt_nxt;
      gcnt_r   <= gcnt_nxt;
      payok_r  <= payok_nxt;
      change_r <= change_nxt;
      reject_r <= reject_nxt;
      err_r    <= err_nxt;
    end
  end

  // Select the decimal digit under scan and decide whether it is a leading zero.
  always_comb begin
    bcd_s     = bin2bcd(14'(credit_r));
    high_s    = bcd_s >> {digit_r, 2'b00};
    dig_val_s = high_s[3:0];
    blank_s   = (digit_r != 2'd0) && (high_s == 16'd0);
  end

  // Digit scan timer and registered segment/enable drive.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      scan_cnt_r <= {SCW{1'b0}};
      digit_r    <= 2'd0;
      seg_r      <= 7'h40;
      ctrl_r     <= ~(DIGITS'(1'b1));
    end else begin
      if (scan_cnt_r == SCW'(SCAN_DIV - 1)) begin
        scan_cnt_r <= {SCW{1'b0}};
        if (digit_r == 2'(DIGITS - 1)) digit_r <= 2'd0;
        else                           digit_r <= digit_r + 2'd1;
      end else begin
        scan_cnt_r <= scan_cnt_r + 1'b1;
      end
      seg_r  <= blank_s ? 7'h7F : seg_of(dig_val_s);
      ctrl_r <= ~(DIGITS'(1'b1) << digit_r);
    end
  end

  assign pnl.seg    = seg_r;
  assign pnl.ctrl   = ctrl_r;
  assign pnl.payok  = payok_r;
  assign pnl.change = change_r;
  assign pnl.reject = reject_r;
  assign pnl.err    = err_r;

endmodule

// File: tb/tb_vend_mux_ctrl.sv
// Scoreboard bench for vend_mux_ctrl: stimulus queues expected status events
// and display digits, an independent monitor matches them as the DUT emits.
module tb_vend_mux_ctrl;

  localparam int DIGITS = 2;

  logic ck = 1'b0;
  logic reset = 1'b0;

  vend_mux_ctrl_if #(.DIGITS(DIGITS)) pnl ();

  vend_mux_ctrl #(
    .PRICE(15), .MAX_CREDIT(95), .DIGITS(DIGITS), .DB_CYCLES(2),
    .SCAN_DIV(4), .VEND_CYCLES(3), .PULSE_GAP(3)
  ) dut (
    .ck(ck),
    .reset(reset),
    .pnl(pnl)
  );

  always #5 ck = ~ck;

  typedef struct {
    int         dig;
    logic [6:0] seg;
  } disp_t;

  int    checks = 0;
  int    passes = 0;
  int    cyc = 0;
  int    pay_len = 0;
  int    last_chg = 0;
  int    q_chg[$];   // expected gap to previous pulse / payok fall, -1 = any
  int    q_pay[$];   // expected payok length
  int    q_rej[$];
  int    q_err[$];
  disp_t q_disp[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic no_expect(input string name);
    checks++;
    $display("FAIL %s: event seen with got 1 expected 0", name);
  endtask

  function automatic logic [1:0] ctrl_for(input int dig);
    logic [1:0] m;
    m = 2'b01 << dig;
    return ~m;
  endfunction

  // Monitor: match every emitted event against the scoreboard.
  always @(negedge ck) begin
    cyc++;
    if (!reset) begin
      pay_len = 0;
    end else begin
      if (pnl.payok) begin
        pay_len++;
      end else if (pay_len > 0) begin
        if (q_pay.size() > 0) check("payok_len", pay_len, q_pay.pop_front());
        else no_expect("unexpected_payok");
        pay_len  = 0;
        last_chg = cyc;
      end
      if (pnl.change) begin
        if (q_chg.size() > 0) begin
          int g;
          g = q_chg.pop_front();
          if (g >= 0) check("change_gap", cyc - last_chg, g);
          else begin checks++; passes++; end
        end else no_expect("unexpected_change");
        last_chg = cyc;
      end
      if (pnl.reject) begin
        if (q_rej.size() > 0) begin void'(q_rej.pop_front()); checks++; passes++; end
        else no_expect("unexpected_reject");
      end
      if (pnl.err) begin
        if (q_err.size() > 0) begin void'(q_err.pop_front()); checks++; passes++; end
        else no_expect("unexpected_err");
      end
      if (q_disp.size() > 0 && pnl.ctrl == ctrl_for(q_disp[0].dig)) begin
        disp_t e;
        e = q_disp.pop_front();
        check($sformatf("seg_digit%0d", e.dig), int'(pnl.seg), int'(e.seg));
      end
    end
  end

  task automatic expect_disp(input logic [6:0] d1, input logic [6:0] d0);
    disp_t e;
    e.dig = 1; e.seg = d1; q_disp.push_back(e);
    e.dig = 0; e.seg = d0; q_disp.push_back(e);
  endtask

  // Wait (bounded) until every expectation is consumed, then let things settle.
  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q_chg.size() == 0 && q_pay.size() == 0 && q_rej.size() == 0 &&
          q_err.size() == 0 && q_disp.size() == 0) break;
      @(negedge ck);
    end
    if (q_chg.size() != 0 || q_pay.size() != 0 || q_rej.size() != 0 ||
        q_err.size() != 0 || q_disp.size() != 0) begin
      checks++;
      $display("FAIL idle_timeout: pending chg=%0d pay=%0d rej=%0d err=%0d disp=%0d expected all 0",
               q_chg.size(), q_pay.size(), q_rej.size(), q_err.size(), q_disp.size());
      q_chg.delete(); q_pay.delete(); q_rej.delete(); q_err.delete(); q_disp.delete();
    end
    repeat (12) @(negedge ck);
  endtask

  task automatic drive(input logic [4:0] low);
    pnl.co5    = ~low[0];
    pnl.co10   = ~low[1];
    pnl.co50   = ~low[2];
    pnl.pay    = ~low[3];
    pnl.cancel = ~low[4];
  endtask

  // mask bits: 0 co5, 1 co10, 2 co50, 3 pay, 4 cancel
  task automatic press(input logic [4:0] mask);
    @(posedge ck); #1;
    drive(mask);
    repeat (6) @(posedge ck);
    #1;
    drive(5'b00000);
    repeat (6) @(posedge ck);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"},    int'(pnl.seg), 'h40);
    check({tag, "_ctrl"},   int'(pnl.ctrl), 2);
    check({tag, "_payok"},  int'(pnl.payok), 0);
    check({tag, "_change"}, int'(pnl.change), 0);
    check({tag, "_reject"}, int'(pnl.reject), 0);
    check({tag, "_err"},    int'(pnl.err), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(5'b00000);
    reset = 1'b0;
    repeat (3) @(posedge ck);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (4) @(posedge ck);

    // 10 + 5 + 10 = 25, pay 15, two change pulses
    press(5'b00010); press(5'b00001); press(5'b00010);
    expect_disp(7'h24, 7'h12);
    wait_idle(60);
    q_pay.push_back(3);
    q_chg.push_back(0); q_chg.push_back(3);
    press(5'b01000);
    wait_idle(60);
    expect_disp(7'h7F, 7'h40);
    wait_idle(60);

    // 50, rejected 50, climb to 90, reject, 95 exactly, reject
    press(5'b00100);
    q_rej.push_back(1);
    press(5'b00100);
    expect_disp(7'h12, 7'h40);
    wait_idle(60);
    repeat (4) press(5'b00010);
    q_rej.push_back(1);
    press(5'b00010);
    press(5'b00001);
    q_rej.push_back(1);
    press(5'b00001);
    expect_disp(7'h10, 7'h12);
    wait_idle(60);
    // refund 95 = 19 pulses; a coin during the train is refused
    q_chg.push_back(-1);
    for (int i = 0; i < 18; i++) q_chg.push_back(3);
    press(5'b10000);
    q_rej.push_back(1);
    press(5'b00010);
    wait_idle(200);
    expect_disp(7'h7F, 7'h40);
    wait_idle(60);

    // credit 10, pay too early, then cancel
    press(5'b00010);
    q_err.push_back(1);
    press(5'b01000);
    expect_disp(7'h79, 7'h40);
    wait_idle(60);
    q_chg.push_back(-1); q_chg.push_back(3);
    press(5'b10000);
    wait_idle(60);
    expect_disp(7'h7F, 7'h40);
    wait_idle(60);

    // co5 and co50 together -> 50 only
    press(5'b00101);
    expect_disp(7'h12, 7'h40);
    wait_idle(60);
    q_chg.push_back(-1);
    for (int i = 0; i < 9; i++) q_chg.push_back(3);
    press(5'b10000);
    wait_idle(120);
    // credit 20, pay and cancel together -> refund 4 pulses, no vend
    press(5'b00010); press(5'b00010);
    expect_disp(7'h24, 7'h40);
    wait_idle(60);
    q_chg.push_back(-1); q_chg.push_back(3); q_chg.push_back(3); q_chg.push_back(3);
    press(5'b11000);
    wait_idle(80);

    // single-cycle glitch on co10 is ignored; then credit 5 blanks digit 1
    @(posedge ck); #1; pnl.co10 = 1'b0;
    @(posedge ck); #1; pnl.co10 = 1'b1;
    repeat (10) @(posedge ck);
    expect_disp(7'h7F, 7'h40);
    wait_idle(60);
    press(5'b00001);
    expect_disp(7'h7F, 7'h12);
    wait_idle(60);

    // credit 15, cancel, reset right after the first change pulse
    press(5'b00010);
    wait_idle(60);
    q_chg.push_back(-1);
    @(posedge ck); #1; pnl.cancel = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge ck);
        if (pnl.change) begin seen = 1'b1; break; end
      end
      check("first_refund_pulse_seen", int'(seen), 1);
    end
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("midchange_reset");
    pnl.cancel = 1'b1;
    repeat (3) @(posedge ck);
    #1 reset = 1'b1;
    repeat (30) @(negedge ck);
    expect_disp(7'h7F, 7'h40);
    wait_idle(60);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
